imem_loadable: RTL and testbench

Parametrised, run-time loadable instruction memory for the MIPS core. Replaces the fixed, file-initialised asynchronous ROM with a synchronous-read RAM. A boot loader port fills it word by word over a valid/ready handshake. A registered fetch port serves the core with one-cycle latency, and any address beyond the loaded program length reads as 0x00000000 (MIPS NOP).

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_ram.sv | 39 +++
 rtl/imem_loadable.sv | 169 ++++++++++++++++
 tb/tb_imem_loadable.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg
// Shared definitions for the loadable instruction memory:
//   - imemState_t : controller states (EMPTY, LOAD, RUN)
//   - NOP         : MIPS no-op word returned for unloaded addresses
//   - evenParity  : even-parity bit over a zero-extended word
package imem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imemState_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Widest word the parity helper accepts; callers zero-extend with a cast.
  localparam int PARITY_MAX_W = 64;

  // XOR of all bits: storing this alongside the word makes the whole
  // entry have an even number of ones.
  function automatic logic evenParity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram
// Plain simple-dual-port RAM array: one synchronous write port and one
// synchronous read port. No reset, so it maps onto block RAM.
// Ports:
//   clock        in   rising-edge clock
//   writeEn      in   write strobe
//   writeAddr    in   write word address
//   writeData    in   write word
//   readEn       in   read strobe; readData updates only when set
//   readAddr     in   read word address
//   readData     out  registered read word (holds between reads)
module imem_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] readAddr,
  output logic [WIDTH-1:0]  readData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read; the read register holds its value when
  // readEn is low so the fetch port can keep presenting the last word.
  always_ff @(posedge clock) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
    if (readEn) begin
      readData <= mem[readAddr];
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// imem_loadable
// Run-time loadable instruction memory for the MIPS core. A boot loader
// fills the RAM word by word over a valid/ready handshake; the core then
// fetches with one-cycle latency. Addresses at or beyond the loaded length
// read as NOP.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and report mismatches on ParityErr (tied 0 otherwise).
// Ports:
//   CLK, RESET   clock and asynchronous active-high reset
//   LoadStart    pulse: (re)start a load at word 0
//   LoadValid    loader word valid
//   LoadData     loader word
//   LoadLast     marks the final program word
//   LoadReady    out: high while in LOAD
//   Busy         out: high in EMPTY and LOAD (core must stall)
//   Length       out: number of words loaded (ADDR_W+1 bits)
//   FetchReq     fetch request
//   FetchAddr    fetch word address
//   FetchValid   out: FetchData valid this cycle
//   FetchData    out: fetched instruction
//   ParityErr    out: parity mismatch on the current fetched word
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LoadStart,
  input  logic              LoadValid,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              LoadLast,
  output logic              LoadReady,
  output logic              Busy,
  output logic [ADDR_W:0]   Length,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic              FetchValid,
  output logic [DATA_W-1:0] FetchData,
  output logic              ParityErr
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  imemState_t        state;
  imemState_t        nextState;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W:0]   lengthQ;
  logic              accept;
  logic              fetchAccept;
  logic              fetchValidQ;
  logic              inRangeQ;
  logic [RAM_W-1:0]  ramWriteData;
  logic [RAM_W-1:0]  ramReadData;

  // Handshake qualifiers. LoadStart wins over everything: a restart drops a
  // word offered in the same cycle, and a reload drops a same-cycle fetch.
  always_comb begin
    accept      = (state == LOAD) && LoadValid && !LoadStart;
    fetchAccept = (state == RUN) && FetchReq && !LoadStart;
  end

  // Next-state logic. The last pointer value (all ones) ends the load even
  // without LoadLast, so a full memory always reaches RUN.
  always_comb begin
    nextState = state;
    case (state)
      EMPTY: begin
        if (LoadStart) nextState = LOAD;
      end
      LOAD: begin
        if (LoadStart) begin
          nextState = LOAD;
        end else if (accept && (LoadLast || (&wrPtr))) begin
          nextState = RUN;
        end
      end
      RUN: begin
        if (LoadStart) nextState = LOAD;
      end
      default: nextState = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Write pointer and loaded length. Length is one bit wider than the
  // pointer so a full load reads as DEPTH instead of wrapping to 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wrPtr   <= '0;
      lengthQ <= '0;
    end else if (LoadStart) begin
      wrPtr   <= '0;
      lengthQ <= '0;
    end else if (accept) begin
      wrPtr   <= wrPtr + ADDR_W'(1);
      lengthQ <= {1'b0, wrPtr} + (ADDR_W + 1)'(1);
    end
  end

  // Fetch pipeline register. inRangeQ only updates on an accepted fetch so
  // that FetchData (RAM output masked by inRangeQ) holds between requests;
  // its reset value of 0 forces FetchData to NOP before any fetch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetchValidQ <= 1'b0;
      inRangeQ    <= 1'b0;
    end else begin
      fetchValidQ <= fetchAccept;
      if (fetchAccept) begin
        inRangeQ <= ({1'b0, FetchAddr} < lengthQ);
      end
    end
  end

`ifdef IMEM_PARITY_EN
  always_comb begin
    ramWriteData = {evenParity(PARITY_MAX_W'(LoadData)), LoadData};
  end
`else
  always_comb begin
    ramWriteData = LoadData;
  end
`endif

  imem_ram #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) uRam (
    .clock    (CLK),
    .writeEn  (accept),
    .writeAddr(wrPtr),
    .writeData(ramWriteData),
    .readEn   (fetchAccept),
    .readAddr (FetchAddr),
    .readData (ramReadData)
  );

  assign LoadReady  = (state == LOAD);
  assign Busy       = (state != RUN);
  assign Length     = lengthQ;
  assign FetchValid = fetchValidQ;
  assign FetchData  = inRangeQ ? ramReadData[DATA_W-1:0] : DATA_W'(NOP);

`ifdef IMEM_PARITY_EN
  // A stored entry with correct parity XORs to 0 over all RAM_W bits.
  // Out-of-range words are NOP, not RAM contents, so they never flag.
  assign ParityErr = fetchValidQ && inRangeQ && (^ramReadData);
`else
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable
// Directed bench for imem_loadable. Fetch expectations are pushed into a
// queue when a fetch is issued; a monitor pops and compares whenever
// FetchValid is seen. Control outputs are checked directly by the driver.
module tb_imem_loadable;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              LoadStart = 1'b0;
  logic              LoadValid = 1'b0;
  logic [DATA_W-1:0] LoadData = '0;
  logic              LoadLast = 1'b0;
  logic              LoadReady;
  logic              Busy;
  logic [ADDR_W:0]   Length;
  logic              FetchReq = 1'b0;
  logic [ADDR_W-1:0] FetchAddr = '0;
  logic              FetchValid;
  logic [DATA_W-1:0] FetchData;
  logic              ParityErr;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
  } expect_t;

  expect_t           expQ[$];
  logic [DATA_W-1:0] progWords [DEPTH];
  int                checkCount = 0;
  int                errorCount = 0;

  imem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .LoadStart (LoadStart),
    .LoadValid (LoadValid),
    .LoadData  (LoadData),
    .LoadLast  (LoadLast),
    .LoadReady (LoadReady),
    .Busy      (Busy),
    .Length    (Length),
    .FetchReq  (FetchReq),
    .FetchAddr (FetchAddr),
    .FetchValid(FetchValid),
    .FetchData (FetchData),
    .ParityErr (ParityErr)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checkCount++;
    if (actual !== required) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Drive all inputs, then advance to 1ns after the next rising edge.
  task automatic applyStimulus(input logic lStart, input logic lValid,
                               input logic [DATA_W-1:0] lData, input logic lLast,
                               input logic fReq, input logic [ADDR_W-1:0] fAddr);
    LoadStart = lStart;
    LoadValid = lValid;
    LoadData  = lData;
    LoadLast  = lLast;
    FetchReq  = fReq;
    FetchAddr = fAddr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Start a load and stream n words from progWords, one accept per cycle.
  task automatic loadProgram(input int n, input logic useLast);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("loadReadyAfterStart", 64'(LoadReady), 64'(1));
    checkOutput("lengthAfterStart", 64'(Length), 64'(0));
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, progWords[i], useLast && (i == n - 1), 1'b0, '0);
    end
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
  endtask

  task automatic fetchWord(input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] expData, input logic expPerr);
    expQ.push_back('{data: expData, perr: expPerr});
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, addr);
  endtask

  // Scoreboard monitor: samples on the falling edge, mid-cycle.
  always @(negedge CLK) begin
    if (!RESET && FetchValid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpectedFetchValid actual=1 required=0 data=%0h", FetchData);
      end else begin
        expect_t e;
        e = expQ.pop_front();
        checkOutput("fetchData", 64'(FetchData), 64'(e.data));
        checkOutput("parityErr", 64'(ParityErr), 64'(e.perr));
      end
    end
  end

  initial begin
    // Reset state.
    idle();
    idle();
    checkOutput("resetBusy", 64'(Busy), 64'(1));
    checkOutput("resetLength", 64'(Length), 64'(0));
    checkOutput("resetLoadReady", 64'(LoadReady), 64'(0));
    checkOutput("resetFetchValid", 64'(FetchValid), 64'(0));
    checkOutput("resetFetchData", 64'(FetchData), 64'(0));
    checkOutput("resetParityErr", 64'(ParityErr), 64'(0));
    RESET = 1'b0;

    // EMPTY ignores fetches.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
      checkOutput("emptyFetchValid", 64'(FetchValid), 64'(0));
    end
    idle();
    checkOutput("emptyBusy", 64'(Busy), 64'(1));
    checkOutput("emptyLength", 64'(Length), 64'(0));

    // Three-word program with LoadLast.
    progWords[0] = 32'h2008_0005;
    progWords[1] = 32'h2108_0001;
    progWords[2] = 32'hAC08_0000;
    loadProgram(3, 1'b1);
    checkOutput("load3Length", 64'(Length), 64'(3));
    checkOutput("load3Busy", 64'(Busy), 64'(0));
    checkOutput("load3LoadReady", 64'(LoadReady), 64'(0));
    fetchWord(6'd0, 32'h2008_0005, 1'b0);
    fetchWord(6'd1, 32'h2108_0001, 1'b0);
    fetchWord(6'd2, 32'hAC08_0000, 1'b0);
    fetchWord(6'd3, 32'h0000_0000, 1'b0);
    fetchWord(6'd1, 32'h2108_0001, 1'b0);
    idle();
    idle();
    checkOutput("holdFetchValid", 64'(FetchValid), 64'(0));
    checkOutput("holdFetchData", 64'(FetchData), 64'(32'h2108_0001));

    // Full 64-word load with no LoadLast.
    for (int i = 0; i < DEPTH; i++) begin
      progWords[i] = 32'hC000_0000 + 32'(i) * 32'h0001_0007;
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, progWords[i], 1'b0, 1'b0, '0);
      if (i == DEPTH - 2) begin
        checkOutput("load63Busy", 64'(Busy), 64'(1));
        checkOutput("load63Length", 64'(Length), 64'(63));
      end
    end
    LoadValid = 1'b0;
    checkOutput("load64Length", 64'(Length), 64'(64));
    checkOutput("load64Busy", 64'(Busy), 64'(0));
    fetchWord(6'd63, 32'hC000_0000 + 32'd63 * 32'h0001_0007, 1'b0);
    fetchWord(6'd0, 32'hC000_0000, 1'b0);
    idle();

    // Reload beats a simultaneous fetch.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 6'd5);
    checkOutput("reloadFetchValid", 64'(FetchValid), 64'(0));
    checkOutput("reloadLoadReady", 64'(LoadReady), 64'(1));
    checkOutput("reloadLength", 64'(Length), 64'(0));
    checkOutput("reloadBusy", 64'(Busy), 64'(1));

    // Two of four words, then an asynchronous reset.
    applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, '0);
    LoadValid = 1'b0;
    checkOutput("partialLength", 64'(Length), 64'(2));
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("midLoadResetLength", 64'(Length), 64'(0));
    checkOutput("midLoadResetBusy", 64'(Busy), 64'(1));
    checkOutput("midLoadResetLoadReady", 64'(LoadReady), 64'(0));
    idle();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
      checkOutput("postResetFetchValid", 64'(FetchValid), 64'(0));
    end

    // New four-word load; address 4 still holds old data but must mask.
    for (int i = 0; i < 4; i++) begin
      progWords[i] = 32'h3C01_1230 + 32'(i);
    end
    loadProgram(4, 1'b1);
    checkOutput("load4Length", 64'(Length), 64'(4));
    fetchWord(6'd0, 32'h3C01_1230, 1'b0);
    fetchWord(6'd3, 32'h3C01_1233, 1'b0);
    fetchWord(6'd4, 32'h0000_0000, 1'b0);
    idle();

`ifdef IMEM_PARITY_EN
    dut.uRam.mem[1][5] = ~dut.uRam.mem[1][5];
    fetchWord(6'd1, 32'h3C01_1231 ^ 32'h0000_0020, 1'b1);
    fetchWord(6'd0, 32'h3C01_1230, 1'b0);
    idle();
`endif

    idle();
    idle();
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
